pcie_dma_req_split: RTL and testbench

Splits DMA transfer descriptors into PCIe-legal memory requests. Each request is no larger than the Max Payload Size (MPS) and never crosses a 4 KB address boundary. The block sits directly downstream of the descriptor prefetch FIFO and consumes its valid/ready output. Its request stream feeds the TLP header builder.

---
 rtl/pcie_dma_pkg.sv | 14 +
 rtl/pcie_dma_chunk_calc.sv | 19 +
 rtl/pcie_dma_req_split.sv | 98 +++++++++
 tb/tb_pcie_dma_req_split.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared MPS codes, FSM states and request field bundle for the DMA request splitter.
package pcie_dma_pkg;
  typedef enum logic [2:0] {MPS_128, MPS_256, MPS_512, MPS_1K, MPS_2K, MPS_4K} mps_e;
  localparam int unsigned BOUNDARY_4K = 4096;
  typedef enum logic {IDLE, SPLIT} state_t;
  typedef struct packed {
    logic [10:0] len_dw;
    logic        first;
    logic        last;
  } req_fields_t;
  function automatic logic [10:0] mps_to_dw(input logic [2:0] mps);
    return (mps > 3'(MPS_4K)) ? 11'(BOUNDARY_4K >> 2) : 11'd32 << mps;
  endfunction
endpackage

// File: rtl/pcie_dma_chunk_calc.sv
// pcie_dma_chunk_calc: size of the next request, limited by remaining length and the MPS-aligned window.
module pcie_dma_chunk_calc
  import pcie_dma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [LEN_W-1:0]  rem,
  input  logic [10:0]       mps_dw,
  output logic [10:0]       chunk,
  output logic              last
);
  logic [10:0] off, room;
  assign off   = 11'((cur_addr >> 2) & ADDR_W'(mps_dw - 11'd1));
  assign room  = mps_dw - off;
  assign chunk = (rem < LEN_W'(room)) ? 11'(rem) : room;
  assign last  = rem == LEN_W'(chunk);
endmodule

// File: rtl/pcie_dma_req_split.sv
// pcie_dma_req_split: splits DMA descriptors into MPS-sized, 4 KB-safe requests.
// Optional PCIE_DMA_SPLIT_STAT_EN adds descriptor/request counters.
module pcie_dma_req_split
  import pcie_dma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16,
  parameter int ID_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mps,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len_dw,
  input  logic [ID_W-1:0]   desc_id,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [10:0]       req_len_dw,
  output logic [ID_W-1:0]   req_id,
  output logic              req_first,
  output logic              req_last
`ifdef PCIE_DMA_SPLIT_STAT_EN
  ,
  output logic [31:0]       stat_desc_cnt,
  output logic [31:0]       stat_req_cnt
`endif
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rem;
  logic [ID_W-1:0]   id;
  logic [10:0]       mps_dw, chunk;
  logic              first, last, load, accept;
  req_fields_t       req_f;
  pcie_dma_chunk_calc #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_calc (
    .cur_addr(cur_addr),
    .rem     (rem),
    .mps_dw  (mps_dw),
    .chunk   (chunk),
    .last    (last)
  );
  assign desc_ready = state == IDLE;
  assign accept     = desc_ready && desc_valid;
  assign load       = state == SPLIT && (!req_valid || req_ready);
  assign req_len_dw = req_f.len_dw;
  assign req_first  = req_f.first;
  assign req_last   = req_f.last;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = (desc_len_dw != '0) ? SPLIT : IDLE;
    if (load && last) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      rem       <= '0;
      id        <= '0;
      mps_dw    <= '0;
      first     <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_id    <= '0;
      req_f     <= '0;
    end else begin
      if (accept) begin
        cur_addr <= desc_addr & ~ADDR_W'(3);
        rem      <= desc_len_dw;
        id       <= desc_id;
        mps_dw   <= mps_to_dw(mps);
        first    <= 1'b1;
      end else if (load) begin
        cur_addr <= cur_addr + ADDR_W'({chunk, 2'b00});
        rem      <= rem - LEN_W'(chunk);
        first    <= 1'b0;
        req_addr <= cur_addr;
        req_id   <= id;
        req_f    <= '{len_dw: chunk, first: first, last: last};
      end
      req_valid <= load ? 1'b1 : (req_ready ? 1'b0 : req_valid);
    end
  end
`ifdef PCIE_DMA_SPLIT_STAT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_desc_cnt <= '0;
      stat_req_cnt  <= '0;
    end else begin
      stat_desc_cnt <= stat_desc_cnt + 32'(accept);
      stat_req_cnt  <= stat_req_cnt + 32'(req_valid && req_ready);
    end
`endif
endmodule

// File: tb/tb_pcie_dma_req_split.sv
// tb_pcie_dma_req_split: scoreboard bench; directed descriptors push expected requests, a monitor pops on handshake.
module tb_pcie_dma_req_split;
  logic        clk = 0, rst_n = 0;
  logic [2:0]  mps = 0;
  logic        desc_valid = 0, desc_ready;
  logic [63:0] desc_addr = 0;
  logic [15:0] desc_len_dw = 0;
  logic [7:0]  desc_id = 0;
  logic        req_valid, req_ready = 1;
  logic [63:0] req_addr;
  logic [10:0] req_len_dw;
  logic [7:0]  req_id;
  logic        req_first, req_last;
`ifdef PCIE_DMA_SPLIT_STAT_EN
  logic [31:0] stat_desc_cnt, stat_req_cnt;
  logic [31:0] desc_cnt_before;
`endif
  pcie_dma_req_split dut (
`ifdef PCIE_DMA_SPLIT_STAT_EN
    .stat_desc_cnt(stat_desc_cnt),
    .stat_req_cnt (stat_req_cnt),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .mps        (mps),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_len_dw(desc_len_dw),
    .desc_id    (desc_id),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len_dw (req_len_dw),
    .req_id     (req_id),
    .req_first  (req_first),
    .req_last   (req_last)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [63:0] addr;
    logic [10:0] len;
    logic [7:0]  id;
    logic        first;
    logic        last;
  } exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, t_first = 0, t_last = 0, hs_since_rst = 0;
  logic have_prev = 0;
  exp_t prev;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t cur();
    return '{req_addr, req_len_dw, req_id, req_first, req_last};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) have_prev = 0;
    else begin
      if (have_prev) chk("hold", {req_valid, cur()}, {1'b1, prev});
      have_prev = req_valid && !req_ready;
      prev = cur();
      if (req_valid && req_ready) begin
        hs_since_rst++;
        if (exp_q.size() == 0) chk("unexpected_req", {1'b1, cur()}, {1'b0, cur()});
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("req", cur(), e);
          if (e.first) t_first = cyc;
          if (e.last) t_last = cyc;
        end
      end
    end
  end
  task automatic push(input logic [63:0] a, input logic [10:0] l, input logic [7:0] i, input logic f, input logic z);
    exp_q.push_back('{a, l, i, f, z});
  endtask
  task automatic send(input logic [63:0] a, input logic [15:0] l, input logic [7:0] i, input logic [2:0] m);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    desc_valid = 1; desc_addr = a; desc_len_dw = l; desc_id = i; mps = m;
    do begin
      @(negedge clk);
      n++;
    end while (!desc_ready && n < 200);
    if (!desc_ready) chk("desc_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    desc_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 96'(exp_q.size()), 0);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end
  initial begin
    #1;
    chk("reset_state", {req_valid, desc_ready, req_addr, req_len_dw, req_id, req_first, req_last},
        {1'b0, 1'b1, 64'h0, 11'd0, 8'h0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // aligned 256 DW at MPS 128B
    for (int i = 0; i < 8; i++) push(64'(i * 'h80), 11'd32, 8'h11, i == 0, i == 7);
    send(64'h0, 16'd256, 8'h11, 3'd0);
    drain();
    chk("back_to_back", 96'(t_last - t_first), 96'd7);
    // 4 KB crossing
    push(64'h0FF0, 11'd4, 8'h22, 1, 0);
    push(64'h1000, 11'd12, 8'h22, 0, 1);
    send(64'h0FF0, 16'd16, 8'h22, 3'd5);
    drain();
    // reserved MPS code, unaligned low bits ignored
    push(64'h0, 11'd1024, 8'h33, 1, 0);
    push(64'h1000, 11'd976, 8'h33, 0, 1);
    send(64'h3, 16'd2000, 8'h33, 3'd7);
    drain();
    // zero length is dropped
`ifdef PCIE_DMA_SPLIT_STAT_EN
    desc_cnt_before = stat_desc_cnt;
`endif
    send(64'h500, 16'd0, 8'h5A, 3'd0);
    chk("zero_len_idle", {desc_ready, req_valid}, {1'b1, 1'b0});
`ifdef PCIE_DMA_SPLIT_STAT_EN
    chk("stat_desc_cnt", stat_desc_cnt, desc_cnt_before + 1);
`endif
    push(64'h104, 11'd1, 8'h5B, 1, 1);
    send(64'h104, 16'd1, 8'h5B, 3'd0);
    drain();
    // backpressure
    req_ready = 0;
    push(64'h40, 11'd16, 8'h44, 1, 0);
    push(64'h80, 11'd24, 8'h44, 0, 1);
    send(64'h40, 16'd40, 8'h44, 3'd0);
    mps = 3'd5;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid", {req_valid, req_addr, req_len_dw}, {1'b1, 64'h40, 11'd16});
    req_ready = 1;
    drain();
    // reset in the middle of a split
    for (int i = 0; i < 4; i++) push(64'h2000 + 64'(i * 'h80), 11'd32, 8'h77, i == 0, i == 3);
    send(64'h2000, 16'd128, 8'h77, 3'd0);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("reset_mid", {req_valid, desc_ready}, {1'b0, 1'b1});
    exp_q.delete();
    hs_since_rst = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    push(64'h300, 11'd8, 8'h99, 1, 1);
    send(64'h300, 16'd8, 8'h99, 3'd0);
    drain();
`ifdef PCIE_DMA_SPLIT_STAT_EN
    chk("stat_req_cnt", stat_req_cnt, 96'(hs_since_rst));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
